control_pwm: RTL and testbench

- Sequencer for the PWM comparator: generates the 10-bit carrier ramp (Frec_Conm) and the duty reference (Corri_Ref) fed to the comparator.
- Accepts new current references over a valid/ready handshake and holds each one in a shadow register.
- Applies the shadow value only at carrier period boundaries, so a PWM pulse is never glitched mid-period.
- Provides enable/disable with a forced-off idle, and an optional soft-start ramp.

---
 rtl/control_pwm.sv | 131 +++++++++++++
 tb/tb_control_pwm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pwm.sv
// PWM sequencer: 10-bit carrier ramp plus a shadowed duty reference applied only at period boundaries.
// Optional soft-start ramp is built when SOFTSTART_EN is defined.
module control_pwm #(
   parameter int PERIOD    = 1000,
   parameter int RAMP_STEP = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [9:0] ref_in,
   input  logic       ref_valid,
   output logic       ref_ready,
   output logic [9:0] Frec_Conm,
   output logic [9:0] Corri_Ref,
   output logic       period_start,
   output logic       running
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RAMP = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   localparam logic [9:0]  LAST   = 10'(PERIOD - 1);
   localparam logic [9:0]  IDLE_C = 10'h3FF;
   localparam logic [10:0] STEP   = 11'(RAMP_STEP);

`ifdef SOFTSTART_EN
   localparam bit SOFTSTART = 1'b1;
`else
   localparam bit SOFTSTART = 1'b0;
`endif

   logic [1:0]  state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [9:0]  cref_q, cref_d;
   logic [9:0]  target_q, target_d;
   logic        pending_q, pending_d;
   logic        ready_q, ready_d;
   logic        ps_q, ps_d;
   logic        running_q, running_d;
   logic        accept;
   logic        ramp_mode;
   logic [10:0] ramp_sum;

   assign accept    = ref_valid & ~pending_q;
   // SOFTSTART is a constant, so the whole RAMP path folds away when disabled.
   assign ramp_mode = SOFTSTART && (state_q == S_RAMP);
   assign ramp_sum  = {1'b0, cref_q} + STEP;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cref_d    = cref_q;
      target_d  = target_q;
      pending_d = pending_q;
      ps_d      = 1'b0;

      if (state_q == S_IDLE) begin
         if (enable) begin
            cnt_d = '0;
            ps_d  = 1'b1;
            if (SOFTSTART) begin
               state_d = S_RAMP;
               cref_d  = '0;
            end else begin
               state_d = S_RUN;
               cref_d  = target_q;
            end
         end
      end else if (!enable) begin
         state_d = S_IDLE;
         cnt_d   = IDLE_C;
         cref_d  = '0;
      end else if (cnt_q == LAST) begin
         cnt_d     = '0;
         ps_d      = 1'b1;
         pending_d = 1'b0;
         if (ramp_mode) begin
            // Saturate at target; reaching it (or target dropping below) ends the ramp.
            if (ramp_sum >= {1'b0, target_q}) begin
               cref_d  = target_q;
               state_d = S_RUN;
            end else begin
               cref_d = ramp_sum[9:0];
            end
         end else begin
            cref_d = target_q;
         end
      end else begin
         cnt_d = 10'(cnt_q + 10'd1);
      end

      // An accept on a boundary cycle lands in target after the old target was applied.
      if (accept) begin
         target_d  = ref_in;
         pending_d = 1'b1;
      end

      ready_d   = ~pending_d;
      running_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= IDLE_C;
         cref_q    <= '0;
         target_q  <= '0;
         pending_q <= 1'b0;
         ready_q   <= 1'b1;
         ps_q      <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cref_q    <= cref_d;
         target_q  <= target_d;
         pending_q <= pending_d;
         ready_q   <= ready_d;
         ps_q      <= ps_d;
         running_q <= running_d;
      end
   end

   assign ref_ready    = ready_q;
   assign Frec_Conm    = cnt_q;
   assign Corri_Ref    = cref_q;
   assign period_start = ps_q;
   assign running      = running_q;

endmodule

// File: tb/tb_control_pwm.sv
// Self-checking bench for control_pwm: directed scenarios plus a randomized run against a reference model.
module tb_control_pwm;

   localparam int PERIOD    = 1000;
   localparam int RAMP_STEP = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [9:0] ref_in = '0;
   logic       ref_valid = 1'b0;
   logic       ref_ready;
   logic [9:0] Frec_Conm;
   logic [9:0] Corri_Ref;
   logic       period_start;
   logic       running;

   int n_pass = 0;
   int n_total = 0;

   control_pwm #(.PERIOD(PERIOD), .RAMP_STEP(RAMP_STEP)) dut (
      .clk(clk), .reset(reset), .enable(enable), .ref_in(ref_in), .ref_valid(ref_valid),
      .ref_ready(ref_ready), .Frec_Conm(Frec_Conm), .Corri_Ref(Corri_Ref),
      .period_start(period_start), .running(running)
   );

   always #5 clk = ~clk;

`ifdef SOFTSTART_EN
   localparam bit SS = 1'b1;
`else
   localparam bit SS = 1'b0;
`endif

   // Reference model: "phase" is the carrier position (-1 while idle), "duty" is the
   // reference the comparator currently sees, "want" is the latest requested reference.
   int m_phase, m_duty, m_want;
   bit m_busy, m_pulse, m_ramping;

   always @(posedge clk) begin
      int  want_before;
      bit  took;
      if (reset) begin
         m_phase = -1; m_duty = 0; m_want = 0; m_busy = 0; m_pulse = 0; m_ramping = 0;
      end else begin
         took        = ref_valid && !m_busy;
         want_before = m_want;
         m_pulse     = 0;
         if (m_phase < 0) begin
            if (enable) begin
               m_phase = 0; m_pulse = 1; m_ramping = SS;
               m_duty  = SS ? 0 : want_before;
            end
         end else if (!enable) begin
            m_phase = -1; m_duty = 0; m_ramping = 0;
         end else begin
            m_phase = (m_phase + 1) % PERIOD;
            if (m_phase == 0) begin
               m_pulse = 1; m_busy = 0;
               if (m_ramping) begin
                  m_duty = (m_duty + RAMP_STEP < want_before) ? m_duty + RAMP_STEP : want_before;
                  if (m_duty == want_before) m_ramping = 0;
               end else begin
                  m_duty = want_before;
               end
            end
         end
         if (took) begin m_want = ref_in; m_busy = 1; end
      end
   end

   task automatic wait_count(input int v, input int budget, input string tag);
      bit found = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (Frec_Conm == 10'(v)) begin found = 1; break; end
      end
      if (!found) begin
         n_total++;
         $display("FAIL %s: count %0d not reached within %0d clocks (last %0d)", tag, v, budget, Frec_Conm);
      end
   endtask

   task automatic test_reset;
      reset = 1; enable = 1; ref_valid = 1; ref_in = 10'd55;
      repeat (3) @(negedge clk);
      n_total++; if (ref_ready !== 1'b1 || running !== 1'b0 || Frec_Conm !== 10'h3FF)
         $display("FAIL reset_override: ready=%b running=%b cnt=%h want 1 0 3ff", ref_ready, running, Frec_Conm);
      else n_pass++;
      reset = 0; enable = 0; ref_valid = 0;
      repeat (50) @(negedge clk);
      n_total++; if (Frec_Conm !== 10'h3FF) $display("FAIL idle_cnt: got %h want 3ff", Frec_Conm); else n_pass++;
      n_total++; if (Corri_Ref !== 10'd0) $display("FAIL idle_ref: got %0d want 0", Corri_Ref); else n_pass++;
      n_total++; if (running !== 1'b0 || period_start !== 1'b0 || ref_ready !== 1'b1)
         $display("FAIL idle_flags: running=%b ps=%b ready=%b want 0 0 1", running, period_start, ref_ready);
      else n_pass++;
   endtask

   task automatic test_run;
      int duty = 0, pulses = 0;
      bit bad_ps = 0, bad_cnt = 0;
      ref_valid = 1; ref_in = 10'd300;
      @(negedge clk);
      ref_valid = 0;
      n_total++; if (ref_ready !== 1'b0) $display("FAIL accept_busy: ready=%b want 0", ref_ready); else n_pass++;
      enable = 1;
      @(negedge clk);
      n_total++; if (Frec_Conm !== 10'd0 || period_start !== 1'b1 || Corri_Ref !== 10'd300 || running !== 1'b1)
         $display("FAIL run_entry: cnt=%0d ps=%b ref=%0d run=%b want 0 1 300 1", Frec_Conm, period_start, Corri_Ref, running);
      else n_pass++;
      for (int i = 0; i < 2 * PERIOD; i++) begin
         if (i > 0) @(negedge clk);
         if (i < PERIOD && Frec_Conm <= Corri_Ref) duty++;
         if (period_start) pulses++;
         if (period_start !== (i % PERIOD == 0)) bad_ps = 1;
         if (Frec_Conm !== 10'(i % PERIOD)) bad_cnt = 1;
      end
      n_total++; if (duty != 301) $display("FAIL run_duty: got %0d want 301", duty); else n_pass++;
      n_total++; if (pulses != 2 || bad_ps) $display("FAIL run_pulses: got %0d misplaced=%b want 2 0", pulses, bad_ps); else n_pass++;
      n_total++; if (bad_cnt) $display("FAIL run_count: sequence broken, got bad=%b want 0", bad_cnt); else n_pass++;
   endtask

   task automatic test_update;
      bit early = 0;
      wait_count(400, 1100, "upd_wait");
      ref_valid = 1; ref_in = 10'd600;
      @(negedge clk);
      ref_in = 10'd700;
      for (int i = 0; i < 700 && Frec_Conm != 10'd0; i++) begin
         if (ref_ready !== 1'b0) early = 1;
         if (Frec_Conm == 10'(PERIOD - 1) && Corri_Ref !== 10'd300) early = 1;
         @(negedge clk);
      end
      n_total++; if (early) $display("FAIL upd_hold: ready or ref changed before boundary, got 1 want 0"); else n_pass++;
      n_total++; if (Frec_Conm !== 10'd0 || Corri_Ref !== 10'd600 || ref_ready !== 1'b1)
         $display("FAIL upd_apply: cnt=%0d ref=%0d ready=%b want 0 600 1", Frec_Conm, Corri_Ref, ref_ready);
      else n_pass++;
      @(negedge clk);
      ref_valid = 0;
      n_total++; if (ref_ready !== 1'b0 || Corri_Ref !== 10'd600)
         $display("FAIL upd_second: ready=%b ref=%0d want 0 600", ref_ready, Corri_Ref);
      else n_pass++;
      wait_count(0, 1100, "upd_wait2");
      n_total++; if (Corri_Ref !== 10'd700) $display("FAIL upd_next: got %0d want 700", Corri_Ref); else n_pass++;
   endtask

   task automatic test_disable;
      wait_count(517, 1100, "dis_wait");
      enable = 0;
      @(negedge clk);
      n_total++; if (Frec_Conm !== 10'h3FF || Corri_Ref !== 10'd0 || running !== 1'b0)
         $display("FAIL dis_idle: cnt=%h ref=%0d run=%b want 3ff 0 0", Frec_Conm, Corri_Ref, running);
      else n_pass++;
      repeat (5) @(negedge clk);
      enable = 1;
      @(negedge clk);
      n_total++; if (Frec_Conm !== 10'd0 || period_start !== 1'b1 || Corri_Ref !== 10'd700 || running !== 1'b1)
         $display("FAIL dis_restart: cnt=%0d ps=%b ref=%0d run=%b want 0 1 700 1", Frec_Conm, period_start, Corri_Ref, running);
      else n_pass++;
   endtask

   task automatic test_extremes;
      int duty = 0;
      ref_valid = 1; ref_in = 10'd1023;
      @(negedge clk);
      ref_valid = 0;
      wait_count(0, 1100, "ext_wait");
      n_total++; if (Corri_Ref !== 10'd1023) $display("FAIL ext_max_ref: got %0d want 1023", Corri_Ref); else n_pass++;
      for (int i = 0; i < PERIOD; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 0) begin ref_valid = 1; ref_in = 10'd0; end
         if (i == 1) ref_valid = 0;
         if (Frec_Conm <= Corri_Ref) duty++;
      end
      n_total++; if (duty != PERIOD) $display("FAIL ext_full_duty: got %0d want %0d", duty, PERIOD); else n_pass++;
      duty = 0;
      @(negedge clk);
      n_total++; if (Corri_Ref !== 10'd0 || Frec_Conm !== 10'd0)
         $display("FAIL ext_zero_ref: ref=%0d cnt=%0d want 0 0", Corri_Ref, Frec_Conm);
      else n_pass++;
      for (int i = 0; i < PERIOD; i++) begin
         if (i > 0) @(negedge clk);
         if (Frec_Conm <= Corri_Ref) duty++;
      end
      n_total++; if (duty != 1) $display("FAIL ext_zero_duty: got %0d want 1", duty); else n_pass++;
   endtask

   task automatic test_softstart;
      int exp_seq[4] = '{0, 8, 16, 20};
      ref_valid = 1; ref_in = 10'd20;
      @(negedge clk);
      ref_valid = 0; enable = 1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) wait_count(0, 1100, "ss_wait");
         n_total++; if (Corri_Ref !== 10'(exp_seq[k]) || running !== 1'b1)
            $display("FAIL ss_step%0d: ref=%0d run=%b want %0d 1", k, Corri_Ref, running, exp_seq[k]);
         else n_pass++;
      end
      wait_count(0, 1100, "ss_hold");
      n_total++; if (Corri_Ref !== 10'd20) $display("FAIL ss_hold: got %0d want 20", Corri_Ref); else n_pass++;
   endtask

   task automatic test_random;
      int bad = 0;
      enable = 1;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (Frec_Conm !== 10'(m_phase < 0 ? 1023 : m_phase) || Corri_Ref !== 10'(m_duty) ||
             ref_ready !== !m_busy || period_start !== m_pulse || running !== (m_phase >= 0)) begin
            if (bad < 5)
               $display("FAIL rand_cycle%0d: cnt=%0d ref=%0d rdy=%b ps=%b run=%b want %0d %0d %b %b %b", i,
                        Frec_Conm, Corri_Ref, ref_ready, period_start, running,
                        m_phase < 0 ? 1023 : m_phase, m_duty, !m_busy, m_pulse, m_phase >= 0);
            bad++;
         end
         if ($urandom_range(0, 399) == 0) enable = ~enable;
         ref_valid = ($urandom_range(0, 3) == 0);
         ref_in    = 10'($urandom_range(0, 1023));
      end
      ref_valid = 0;
      n_total++; if (bad != 0) $display("FAIL rand_model: %0d mismatching cycles, want 0", bad); else n_pass++;
   endtask

   initial begin
      test_reset();
`ifdef SOFTSTART_EN
      test_softstart();
`else
      test_run();
      test_update();
      test_disable();
      test_extremes();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
